// File: rtl/axi_packetizer.sv
// AXI4 slave front end: captures one AW+W burst (up to 4 beats) or one AR request and
// presents it as a single 678-bit packet, with a B response issued once a write packet is taken.
module axi_packetizer #(
   parameter int C_S_AXI_ID_WIDTH   = 16,
   parameter int C_S_AXI_ADDR_WIDTH = 40,
   parameter int C_S_AXI_DATA_WIDTH = 128,
   parameter int C_S_AXI_USER_WIDTH = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [7:0]                      S_AXI_AWLEN,
   input  logic [2:0]                      S_AXI_AWSIZE,
   input  logic [1:0]                      S_AXI_AWBURST,
   input  logic                            S_AXI_AWLOCK,
   input  logic [3:0]                      S_AXI_AWCACHE,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic [3:0]                      S_AXI_AWQOS,
   input  logic [3:0]                      S_AXI_AWREGION,
   input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_AWUSER,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WLAST,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [7:0]                      S_AXI_ARLEN,
   input  logic [2:0]                      S_AXI_ARSIZE,
   input  logic [1:0]                      S_AXI_ARBURST,
   input  logic                            S_AXI_ARLOCK,
   input  logic [3:0]                      S_AXI_ARCACHE,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic [3:0]                      S_AXI_ARQOS,
   input  logic [3:0]                      S_AXI_ARREGION,
   input  logic [C_S_AXI_USER_WIDTH-1:0]   S_AXI_ARUSER,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [677:0]                    packet_out,
   output logic                            packet_valid,
   input  logic                            packet_ready,
   output logic                            proto_error
);

   localparam int META_W   = C_S_AXI_ADDR_WIDTH + C_S_AXI_ID_WIDTH + C_S_AXI_USER_WIDTH + 29;
   localparam int LEN_LSB  = C_S_AXI_USER_WIDTH + 21;
   localparam int ID_LSB   = LEN_LSB + 8;
   localparam int STRB_W   = C_S_AXI_DATA_WIDTH / 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WDATA = 2'd1;
   localparam logic [1:0] S_EMIT  = 2'd2;
   localparam logic [1:0] S_BRESP = 2'd3;

   logic [1:0]                    state_q, state_d;
   logic                          is_write_q;
   logic [META_W-1:0]             meta_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] data_q [4];
   logic [STRB_W-1:0]             strb_q [4];
   logic [2:0]                    beat_idx_q;
   logic                          prio_write_q;
   logic                          proto_err_q;

   logic                          grant_w, in_idle;
   logic                          aw_hs, ar_hs, w_hs, pkt_hs, b_hs;
   logic                          aw_err, w_err;
   logic [7:0]                    burst_len, beat_idx_ext;
   logic [META_W-1:0]             aw_meta, ar_meta;

   assign aw_meta = {S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
                     S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION,
                     S_AXI_AWUSER};
   assign ar_meta = {S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
                     S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION,
                     S_AXI_ARUSER};

   // Round-robin: on a tie the channel that was not handed off last wins.
   assign grant_w       = S_AXI_AWVALID && (!S_AXI_ARVALID || prio_write_q);
   assign in_idle       = (state_q == S_IDLE) && S_AXI_ARESETN;
   assign S_AXI_AWREADY = in_idle && grant_w;
   assign S_AXI_ARREADY = in_idle && !grant_w && S_AXI_ARVALID;
   assign S_AXI_WREADY  = (state_q == S_WDATA);
   assign packet_valid  = (state_q == S_EMIT);
   assign S_AXI_BVALID  = (state_q == S_BRESP);
   assign S_AXI_BID     = meta_q[ID_LSB +: C_S_AXI_ID_WIDTH];
   assign S_AXI_BRESP   = 2'b00;
   assign proto_error   = proto_err_q;

   assign aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign pkt_hs = packet_valid && packet_ready;
   assign b_hs   = S_AXI_BVALID && S_AXI_BREADY;

   // The saturated index still compares correctly against any legal (<=3) burst length.
   assign burst_len    = meta_q[LEN_LSB +: 8];
   assign beat_idx_ext = {5'd0, beat_idx_q};
   assign aw_err       = aw_hs && (S_AXI_AWLEN > 8'd3);
   assign w_err        = w_hs && ((S_AXI_WLAST && (beat_idx_ext != burst_len)) ||
                                  (!S_AXI_WLAST && (beat_idx_ext > burst_len)));

   assign packet_out[677]     = is_write_q;
   assign packet_out[676:576] = meta_q;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_slot
         assign packet_out[575-16*gi -: 16]   = strb_q[gi];
         assign packet_out[511-128*gi -: 128] = data_q[gi];
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (aw_hs) state_d = S_WDATA;
                  else if (ar_hs) state_d = S_EMIT;
         S_WDATA: if (w_hs && S_AXI_WLAST) state_d = S_EMIT;
         S_EMIT:  if (pkt_hs) state_d = is_write_q ? S_BRESP : S_IDLE;
         S_BRESP: if (b_hs) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         state_q      <= S_IDLE;
         is_write_q   <= 1'b0;
         meta_q       <= '0;
         beat_idx_q   <= 3'd0;
         prio_write_q <= 1'b1;
         proto_err_q  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            strb_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (aw_err || w_err) proto_err_q <= 1'b1;
         if (aw_hs || ar_hs) begin
            is_write_q <= aw_hs;
            meta_q     <= aw_hs ? aw_meta : ar_meta;
            beat_idx_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
               data_q[i] <= '0;
               strb_q[i] <= '0;
            end
         end
         // Beats beyond the fourth are accepted but not stored.
         if (w_hs && !beat_idx_q[2]) begin
            data_q[beat_idx_q[1:0]] <= S_AXI_WDATA;
            strb_q[beat_idx_q[1:0]] <= S_AXI_WSTRB;
            beat_idx_q              <= beat_idx_q + 3'd1;
         end
         if (pkt_hs) prio_write_q <= !is_write_q;
      end
   end

endmodule

// File: tb/tb_axi_packetizer.sv
// Bench for axi_packetizer: drives AXI AW/W/AR traffic and compares every packet, B response
// and error flag against a packet model assembled from the field layout.
module tb_axi_packetizer;

   logic         clk = 1'b0;
   logic         S_AXI_ARESETN;
   logic [15:0]  S_AXI_AWID, S_AXI_ARID, S_AXI_AWUSER, S_AXI_ARUSER, S_AXI_BID, S_AXI_WSTRB;
   logic [39:0]  S_AXI_AWADDR, S_AXI_ARADDR;
   logic [7:0]   S_AXI_AWLEN, S_AXI_ARLEN;
   logic [2:0]   S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_AWPROT, S_AXI_ARPROT;
   logic [1:0]   S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP;
   logic         S_AXI_AWLOCK, S_AXI_ARLOCK;
   logic [3:0]   S_AXI_AWCACHE, S_AXI_ARCACHE, S_AXI_AWQOS, S_AXI_ARQOS;
   logic [3:0]   S_AXI_AWREGION, S_AXI_ARREGION;
   logic         S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic [127:0] S_AXI_WDATA;
   logic         S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
   logic         S_AXI_BVALID, S_AXI_BREADY;
   logic [677:0] packet_out;
   logic         packet_valid, packet_ready, proto_error;

   int           n_checks = 0;
   int           n_fail   = 0;
   bit           exp_err  = 1'b0;
   logic [127:0] q_d [$];
   logic [15:0]  q_s [$];

   always #5 clk = ~clk;

   axi_packetizer dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(S_AXI_ARESETN),
      .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
      .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
      .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWQOS(S_AXI_AWQOS),
      .S_AXI_AWREGION(S_AXI_AWREGION), .S_AXI_AWUSER(S_AXI_AWUSER),
      .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
      .S_AXI_ARSIZE(S_AXI_ARSIZE), .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARLOCK(S_AXI_ARLOCK),
      .S_AXI_ARCACHE(S_AXI_ARCACHE), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARQOS(S_AXI_ARQOS),
      .S_AXI_ARREGION(S_AXI_ARREGION), .S_AXI_ARUSER(S_AXI_ARUSER),
      .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
      .packet_out(packet_out), .packet_valid(packet_valid), .packet_ready(packet_ready),
      .proto_error(proto_error)
   );

   // Reference packet: type bit, metadata, then the first four queued beats in slot order.
   function automatic logic [677:0] model_pkt(input bit wr, input logic [100:0] meta);
      logic [677:0] p;
      p = '0;
      p[677] = wr;
      p[676:576] = meta;
      for (int i = 0; i < 4 && i < q_d.size(); i++) begin
         p[575-16*i -: 16]   = q_s[i];
         p[511-128*i -: 128] = q_d[i];
      end
      return p;
   endfunction

   function automatic logic [100:0] aw_meta();
      return {S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST, S_AXI_AWLOCK,
              S_AXI_AWCACHE, S_AXI_AWPROT, S_AXI_AWQOS, S_AXI_AWREGION, S_AXI_AWUSER};
   endfunction

   function automatic logic [100:0] ar_meta();
      return {S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST, S_AXI_ARLOCK,
              S_AXI_ARCACHE, S_AXI_ARPROT, S_AXI_ARQOS, S_AXI_ARREGION, S_AXI_ARUSER};
   endfunction

   task automatic set_aw(input logic [39:0] a, input logic [15:0] id, input logic [7:0] len);
      S_AXI_AWADDR = a; S_AXI_AWID = id; S_AXI_AWLEN = len;
      S_AXI_AWSIZE = 3'($urandom); S_AXI_AWBURST = 2'($urandom); S_AXI_AWLOCK = 1'($urandom);
      S_AXI_AWCACHE = 4'($urandom); S_AXI_AWPROT = 3'($urandom); S_AXI_AWQOS = 4'($urandom);
      S_AXI_AWREGION = 4'($urandom); S_AXI_AWUSER = 16'($urandom);
   endtask

   task automatic set_ar(input logic [39:0] a, input logic [15:0] id, input logic [7:0] len);
      S_AXI_ARADDR = a; S_AXI_ARID = id; S_AXI_ARLEN = len;
      S_AXI_ARSIZE = 3'($urandom); S_AXI_ARBURST = 2'($urandom); S_AXI_ARLOCK = 1'($urandom);
      S_AXI_ARCACHE = 4'($urandom); S_AXI_ARPROT = 3'($urandom); S_AXI_ARQOS = 4'($urandom);
      S_AXI_ARREGION = 4'($urandom); S_AXI_ARUSER = 16'($urandom);
   endtask

   function automatic logic [39:0] rand_addr();
      return {8'($urandom), 32'($urandom)};
   endfunction

   task automatic hs_aw(output int waited);
      bit got = 1'b0;
      waited = 0;
      S_AXI_AWVALID = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (S_AXI_AWREADY === 1'b1) got = 1'b1; else waited++;
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL aw_handshake: AWREADY got 0 required 1 within 20 cycles"); end
      @(negedge clk);
      S_AXI_AWVALID = 1'b0;
   endtask

   task automatic hs_ar(output int waited);
      bit got = 1'b0;
      waited = 0;
      S_AXI_ARVALID = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (S_AXI_ARREADY === 1'b1) got = 1'b1; else waited++;
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL ar_handshake: ARREADY got 0 required 1 within 20 cycles"); end
      @(negedge clk);
      S_AXI_ARVALID = 1'b0;
   endtask

   task automatic hs_w(input logic [127:0] d, input logic [15:0] s, input bit last);
      bit got = 1'b0;
      S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = last; S_AXI_WVALID = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (S_AXI_WREADY === 1'b1) got = 1'b1;
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL w_handshake: WREADY got 0 required 1 within 20 cycles"); end
      @(negedge clk);
      S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
   endtask

   task automatic hs_pkt(output logic [677:0] p);
      bit got = 1'b0;
      p = '0;
      packet_ready = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (packet_valid === 1'b1) begin got = 1'b1; p = packet_out; end
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL packet_handshake: packet_valid got 0 required 1 within 20 cycles"); end
      @(negedge clk);
      packet_ready = 1'b0;
   endtask

   task automatic hs_b(input logic [15:0] id);
      bit got = 1'b0;
      logic [15:0] bid = '0;
      logic [1:0]  bresp = '0;
      S_AXI_BREADY = 1'b1;
      for (int c = 0; c < 20 && !got; c++) begin
         #1;
         if (S_AXI_BVALID === 1'b1) begin got = 1'b1; bid = S_AXI_BID; bresp = S_AXI_BRESP; end
         @(posedge clk);
         if (!got) @(negedge clk);
      end
      n_checks++;
      if (!got || bid !== id || bresp !== 2'b00) begin
         n_fail++;
         $display("FAIL b_response: got valid=%0d bid=%h bresp=%0d required valid=1 bid=%h bresp=0", got, bid, bresp, id);
      end
      @(negedge clk);
      S_AXI_BREADY = 1'b0;
   endtask

   // Sends the beats queued in q_d/q_s as one burst, optionally stalling the packet handoff.
   task automatic run_write(input logic [39:0] a, input logic [15:0] id, input logic [7:0] len,
                            input int stall, output logic [677:0] p);
      logic [100:0] m;
      logic [677:0] exp;
      int waited;
      set_aw(a, id, len);
      m = aw_meta();
      hs_aw(waited);
      if (len > 8'd3) exp_err = 1'b1;
      for (int i = 0; i < q_d.size(); i++) hs_w(q_d[i], q_s[i], i == q_d.size() - 1);
      if (q_d.size() - 1 != int'(len)) exp_err = 1'b1;
      exp = model_pkt(1'b1, m);
      #1;
      n_checks++;
      if (packet_valid !== 1'b1) begin
         n_fail++; $display("FAIL write_latency: packet_valid got %0d required 1", packet_valid);
      end
      for (int k = 0; k < stall; k++) begin
         @(negedge clk);
         S_AXI_AWVALID = 1'b1; S_AXI_ARVALID = 1'b1;
         #1;
         n_checks++;
         if (packet_valid !== 1'b1 || packet_out !== exp || S_AXI_AWREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got valid=%0d awready=%0d arready=%0d pkt=%h required valid=1 readies=0 pkt=%h",
                     packet_valid, S_AXI_AWREADY, S_AXI_ARREADY, packet_out, exp);
         end
      end
      if (stall > 0) begin
         @(negedge clk);
         S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      end
      hs_pkt(p);
      n_checks++;
      if (p !== exp) begin n_fail++; $display("FAIL write_packet: got %h required %h", p, exp); end
      #1;
      n_checks++;
      if (S_AXI_BVALID !== 1'b1) begin n_fail++; $display("FAIL bvalid_after_handoff: got %0d required 1", S_AXI_BVALID); end
      hs_b(id);
      n_checks++;
      if (proto_error !== exp_err) begin
         n_fail++; $display("FAIL write_proto_error: got %0d required %0d", proto_error, exp_err);
      end
      $display("write txn addr=%h id=%h len=%0d beats=%0d", a, id, len, q_d.size());
      q_d.delete(); q_s.delete();
   endtask

   task automatic run_read(input logic [39:0] a, input logic [15:0] id, input logic [7:0] len,
                           output int waited, output logic [677:0] p);
      logic [100:0] m;
      logic [677:0] exp;
      set_ar(a, id, len);
      m = ar_meta();
      hs_ar(waited);
      q_d.delete(); q_s.delete();
      exp = model_pkt(1'b0, m);
      #1;
      n_checks++;
      if (packet_valid !== 1'b1) begin
         n_fail++; $display("FAIL read_latency: packet_valid got %0d required 1", packet_valid);
      end
      hs_pkt(p);
      n_checks++;
      if (p !== exp) begin n_fail++; $display("FAIL read_packet: got %h required %h", p, exp); end
      #1;
      n_checks++;
      if (S_AXI_BVALID !== 1'b0) begin n_fail++; $display("FAIL read_no_bvalid: got %0d required 0", S_AXI_BVALID); end
      $display("read txn addr=%h id=%h len=%0d", a, id, len);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      S_AXI_BREADY = 1'b0; packet_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      S_AXI_ARESETN = 1'b1;
      exp_err = 1'b0;
      q_d.delete(); q_s.delete();
   endtask

   task automatic check_all_zero(input string tag);
      #1;
      n_checks++;
      if (packet_out !== '0 || packet_valid !== 1'b0 || S_AXI_BVALID !== 1'b0 || S_AXI_BID !== '0 ||
          S_AXI_BRESP !== 2'b00 || proto_error !== 1'b0 || S_AXI_WREADY !== 1'b0 ||
          S_AXI_AWREADY !== 1'b0 || S_AXI_ARREADY !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got pv=%0d bv=%0d bid=%h bresp=%0d perr=%0d wr=%0d awr=%0d arr=%0d pkt_nonzero=%0d required all 0",
                  tag, packet_valid, S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, proto_error, S_AXI_WREADY,
                  S_AXI_AWREADY, S_AXI_ARREADY, packet_out != '0);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      check_all_zero("reset_state");
      $display("reset check done");
   endtask

   task automatic test_read();
      int waited;
      logic [677:0] p;
      run_read(40'h12_3456_7800, 16'd5, 8'd3, waited, p);
      n_checks++;
      if (waited != 0) begin n_fail++; $display("FAIL arready_same_cycle: waited %0d cycles required 0", waited); end
      n_checks++;
      if (p[677] !== 1'b0 || p[676:637] !== 40'h12_3456_7800 || p[575:0] !== '0) begin
         n_fail++; $display("FAIL read_fields: got type=%0d addr=%h required type=0 addr=1234567800 zero data", p[677], p[676:637]);
      end
   endtask

   task automatic test_write();
      logic [677:0] p;
      logic [127:0] a, d;
      a = {8{16'hAAAA}};
      d = {8{16'hDDDD}};
      q_d = '{a, {8{16'hBBBB}}, {8{16'hCCCC}}, d};
      q_s = '{16'hFFFF, 16'h0FFF, 16'h00FF, 16'h000F};
      run_write(rand_addr(), 16'h1234, 8'd3, 0, p);
      n_checks++;
      if (p[511:384] !== a || p[127:0] !== d || p[527:512] !== 16'h000F || p[677] !== 1'b1) begin
         n_fail++; $display("FAIL write_fields: got beat0=%h beat3=%h strb3=%h required %h %h 000f", p[511:384], p[127:0], p[527:512], a, d);
      end
   endtask

   task automatic test_round_robin();
      int w_left = 3, r_left = 3;
      logic [677:0] p, exp;
      logic [100:0] m;
      apply_reset();
      set_aw(rand_addr(), 16'($urandom), 8'd0);
      set_ar(rand_addr(), 16'($urandom), 8'($urandom));
      for (int t = 0; t < 6; t++) begin
         bit got = 1'b0, kind_w = 1'b0;
         logic [15:0] id = '0;
         S_AXI_AWVALID = (w_left > 0);
         S_AXI_ARVALID = (r_left > 0);
         for (int c = 0; c < 20 && !got; c++) begin
            #1;
            if (S_AXI_AWREADY === 1'b1) begin got = 1'b1; kind_w = 1'b1; m = aw_meta(); id = S_AXI_AWID; end
            else if (S_AXI_ARREADY === 1'b1) begin got = 1'b1; kind_w = 1'b0; m = ar_meta(); end
            @(posedge clk);
            if (!got) @(negedge clk);
         end
         @(negedge clk);
         n_checks++;
         if (!got || kind_w !== (t % 2 == 0)) begin
            n_fail++; $display("FAIL rr_order: txn %0d got granted=%0d write=%0d required write=%0d", t, got, kind_w, t % 2 == 0);
         end
         q_d.delete(); q_s.delete();
         if (got && kind_w) begin
            w_left--;
            set_aw(rand_addr(), 16'($urandom), 8'd0);
            S_AXI_AWVALID = (w_left > 0);
            q_d.push_back({4{32'($urandom)}});
            q_s.push_back(16'($urandom));
            hs_w(q_d[0], q_s[0], 1'b1);
         end else if (got) begin
            r_left--;
            set_ar(rand_addr(), 16'($urandom), 8'($urandom));
            S_AXI_ARVALID = (r_left > 0);
         end
         exp = model_pkt(kind_w, m);
         hs_pkt(p);
         n_checks++;
         if (p !== exp) begin n_fail++; $display("FAIL rr_packet: txn %0d got %h required %h", t, p, exp); end
         if (kind_w) hs_b(id);
         $display("rr txn %0d granted %s", t, kind_w ? "write" : "read");
      end
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0;
      q_d.delete(); q_s.delete();
   endtask

   task automatic test_single_beat_stall();
      logic [677:0] p;
      q_d.push_back({4{32'($urandom)}});
      q_s.push_back(16'($urandom));
      run_write(rand_addr(), 16'($urandom), 8'd0, 10, p);
      n_checks++;
      if (p[383:0] !== '0 || p[559:512] !== '0) begin
         n_fail++; $display("FAIL single_beat_zero: got slots1-3 nonzero data=%h strb=%h required 0", p[383:0], p[559:512]);
      end
   endtask

   task automatic test_proto_error();
      logic [677:0] p;
      for (int i = 0; i < 6; i++) begin
         q_d.push_back({4{32'($urandom)}});
         q_s.push_back(16'($urandom));
      end
      run_write(rand_addr(), 16'($urandom), 8'd5, 0, p);
      apply_reset();
      #1;
      n_checks++;
      if (proto_error !== 1'b0) begin n_fail++; $display("FAIL proto_error_clear: got %0d required 0", proto_error); end
      for (int i = 0; i < 2; i++) begin
         q_d.push_back({4{32'($urandom)}});
         q_s.push_back(16'($urandom));
      end
      run_write(rand_addr(), 16'($urandom), 8'd2, 0, p);
   endtask

   task automatic test_reset_midburst();
      int waited;
      logic [677:0] p;
      set_aw(rand_addr(), 16'($urandom), 8'd3);
      hs_aw(waited);
      hs_w({4{32'($urandom)}}, 16'hFFFF, 1'b0);
      hs_w({4{32'($urandom)}}, 16'hFFFF, 1'b0);
      S_AXI_ARESETN = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_midburst");
      S_AXI_ARESETN = 1'b1;
      exp_err = 1'b0;
      S_AXI_BREADY = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if (S_AXI_BVALID !== 1'b0 || packet_valid !== 1'b0) begin
            n_fail++; $display("FAIL no_b_after_reset: got bvalid=%0d pvalid=%0d required 0 0", S_AXI_BVALID, packet_valid);
         end
      end
      S_AXI_BREADY = 1'b0;
      @(negedge clk);
      run_read(rand_addr(), 16'($urandom), 8'($urandom), waited, p);
   endtask

   task automatic test_random_mix();
      logic [677:0] p;
      int waited;
      for (int t = 0; t < 10; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            logic [7:0] len = 8'($urandom_range(0, 3));
            for (int i = 0; i <= int'(len); i++) begin
               q_d.push_back({4{32'($urandom)}});
               q_s.push_back(16'($urandom));
            end
            run_write(rand_addr(), 16'($urandom), len, int'($urandom_range(0, 2)), p);
         end else begin
            run_read(rand_addr(), 16'($urandom), 8'($urandom), waited, p);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      S_AXI_ARESETN = 1'b0;
      S_AXI_AWVALID = 1'b0; S_AXI_ARVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_WLAST = 1'b0;
      S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_BREADY = 1'b0; packet_ready = 1'b0;
      set_aw('0, '0, '0);
      set_ar('0, '0, '0);
      test_reset();
      test_read();
      test_write();
      test_round_robin();
      test_single_beat_stall();
      test_proto_error();
      test_reset_midburst();
      test_random_mix();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
